// File: rtl/split_pkg.sv
// Shared types and helpers for the streaming split-constraint evaluator.
package split_pkg;

  typedef enum logic [1:0] {
    MODE_TAUT   = 2'd0,
    MODE_PARITY = 2'd1,
    MODE_SUM    = 2'd2
  } split_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } split_state_e;

  // A beat ends the instance when the sender flags it or the expected count is reached.
  function automatic logic is_terminal(input logic last, input int beat_count,
                                       input int num_vars);
    return last || (beat_count == num_vars);
  endfunction

endpackage

// File: rtl/split_accum.sv
// Parity and modular-sum accumulators; exposes the values they take after the current beat.
module split_accum #(
  parameter int MAX_W = 8,
  parameter int SUM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             first,
  input  logic [MAX_W-1:0] data,
  output logic             parity_nxt,
  output logic [SUM_W-1:0] sum_nxt
);

  logic             parity_q, parity_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    // The first beat of an instance starts from zero regardless of stale contents.
    parity_nxt = (first ? 1'b0 : parity_q) ^ (^data);
    sum_nxt    = (first ? '0 : sum_q) + SUM_W'(data);
    parity_d   = parity_q;
    sum_d      = sum_q;
    if (clr) begin
      parity_d = 1'b0;
      sum_d    = '0;
    end else if (en) begin
      parity_d = parity_nxt;
      sum_d    = sum_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      parity_q <= parity_d;
      sum_q    <= sum_d;
    end
  end

endmodule

// File: rtl/split_stream_eval.sv
// Streams NUM_VARS beats of one instance and returns a registered verdict x plus a framing error.
// Handshakes: a beat moves when in_valid & in_ready; a verdict moves when out_valid & out_ready.
module split_stream_eval
  import split_pkg::*;
#(
  parameter int NUM_VARS = 40,
  parameter int MAX_W    = 8,
  parameter int MODE     = 0,
  parameter int PARITY   = 0,
  parameter int SUM_W    = 12,
  parameter int TARGET   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAX_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x,
  output logic             err
);

  localparam int               CNT_W      = $clog2(NUM_VARS + 1);
  localparam logic             PARITY_BIT = 1'(PARITY);
  localparam logic [SUM_W-1:0] TARGET_V   = SUM_W'(TARGET);

  split_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             x_q, x_d;
  logic             err_q, err_d;

  logic             beat_acc;
  logic [CNT_W-1:0] cnt_inc;
  logic             terminal;
  logic             frame_err;
  logic             verdict;
  logic             first_beat;
  logic             acc_clr;
  logic             parity_nxt;
  logic [SUM_W-1:0] sum_nxt;

  split_accum #(
    .MAX_W (MAX_W),
    .SUM_W (SUM_W)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .clr        (acc_clr),
    .en         (beat_acc),
    .first      (first_beat),
    .data       (in_data),
    .parity_nxt (parity_nxt),
    .sum_nxt    (sum_nxt)
  );

  always_comb begin
    beat_acc   = in_valid & in_ready_q;
    first_beat = (state_q == S_IDLE);
    acc_clr    = (state_q == S_DONE) & out_ready;
    cnt_inc    = first_beat ? CNT_W'(1) : count_q + CNT_W'(1);
    terminal   = beat_acc && is_terminal(in_last, int'(cnt_inc), NUM_VARS);
    // The flag is wrong if it appears early or is missing on the final expected beat.
    frame_err  = in_last != (int'(cnt_inc) == NUM_VARS);

    if (MODE == int'(MODE_PARITY)) begin
      verdict = (parity_nxt == PARITY_BIT);
    end else if (MODE == int'(MODE_SUM)) begin
      verdict = (sum_nxt == TARGET_V);
    end else begin
      verdict = 1'b1;
    end

    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (beat_acc) begin
          count_d = cnt_inc;
          state_d = S_ACCUM;
          if (terminal) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            err_d       = frame_err;
            x_d         = ~frame_err & verdict;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          count_d     = '0;
          out_valid_d = 1'b0;
          x_d         = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        count_d     = '0;
        out_valid_d = 1'b0;
        x_d         = 1'b0;
        err_d       = 1'b0;
      end
    endcase

    in_ready_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign err       = err_q;

endmodule

// File: tb/tb_split_stream_eval.sv
// Bench for split_stream_eval: five configurations on three input lanes, checked against a beat-list model.
module tb_split_stream_eval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lane_valid [3];
  logic [7:0] lane_data  [3];
  logic       lane_last  [3];
  logic       lane_ordy  [3];
  logic       in_ready_w [5];
  logic       out_valid_w[5];
  logic       x_w        [5];
  logic       err_w      [5];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] bq_data[$];
  logic       bq_last[$];

  always #5 clk = ~clk;

  // Lane 0: MODE 0, 40 vars.
  split_stream_eval #(.NUM_VARS(40), .MAX_W(8), .MODE(0), .PARITY(0), .SUM_W(12), .TARGET(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(lane_valid[0]), .in_ready(in_ready_w[0]),
    .in_data(lane_data[0]), .in_last(lane_last[0]), .out_valid(out_valid_w[0]),
    .out_ready(lane_ordy[0]), .x(x_w[0]), .err(err_w[0]));
  // Lane 1: three MODE 2 variants, 4 vars, sharing one stream.
  split_stream_eval #(.NUM_VARS(4), .MAX_W(8), .MODE(2), .PARITY(0), .SUM_W(12), .TARGET(12'h3FC)) u1 (
    .clk(clk), .rst(rst), .in_valid(lane_valid[1]), .in_ready(in_ready_w[1]),
    .in_data(lane_data[1]), .in_last(lane_last[1]), .out_valid(out_valid_w[1]),
    .out_ready(lane_ordy[1]), .x(x_w[1]), .err(err_w[1]));
  split_stream_eval #(.NUM_VARS(4), .MAX_W(8), .MODE(2), .PARITY(0), .SUM_W(12), .TARGET(12'h3FB)) u2 (
    .clk(clk), .rst(rst), .in_valid(lane_valid[1]), .in_ready(in_ready_w[2]),
    .in_data(lane_data[1]), .in_last(lane_last[1]), .out_valid(out_valid_w[2]),
    .out_ready(lane_ordy[1]), .x(x_w[2]), .err(err_w[2]));
  split_stream_eval #(.NUM_VARS(4), .MAX_W(8), .MODE(2), .PARITY(0), .SUM_W(8), .TARGET(8'hFC)) u3 (
    .clk(clk), .rst(rst), .in_valid(lane_valid[1]), .in_ready(in_ready_w[3]),
    .in_data(lane_data[1]), .in_last(lane_last[1]), .out_valid(out_valid_w[3]),
    .out_ready(lane_ordy[1]), .x(x_w[3]), .err(err_w[3]));
  // Lane 2: MODE 1, 3 vars, odd parity required.
  split_stream_eval #(.NUM_VARS(3), .MAX_W(8), .MODE(1), .PARITY(1), .SUM_W(12), .TARGET(0)) u4 (
    .clk(clk), .rst(rst), .in_valid(lane_valid[2]), .in_ready(in_ready_w[4]),
    .in_data(lane_data[2]), .in_last(lane_last[2]), .out_valid(out_valid_w[4]),
    .out_ready(lane_ordy[2]), .x(x_w[4]), .err(err_w[4]));

  function automatic int nv_of(input int d);
    case (d)
      0:       return 40;
      4:       return 3;
      default: return 4;
    endcase
  endfunction

  // Reference: find the terminal beat, then judge the beats up to it with plain arithmetic.
  function automatic void model(input int d, output logic ex, output logic ee, output int term);
    int nv  = nv_of(d);
    int sum = 0;
    int ones = 0;
    term = bq_data.size() - 1;
    for (int i = 0; i < bq_data.size(); i++) begin
      if (bq_last[i] || i == nv - 1) begin
        term = i;
        break;
      end
    end
    ee = (bq_last[term] != (term == nv - 1));
    for (int i = 0; i <= term; i++) begin
      sum  += int'(bq_data[i]);
      ones += $countones(bq_data[i]);
    end
    case (d)
      0:       ex = 1'b1;
      1:       ex = (sum % 4096) == 'h3FC;
      2:       ex = (sum % 4096) == 'h3FB;
      3:       ex = (sum % 256) == 'hFC;
      default: ex = (ones % 2) == 1;
    endcase
    if (ee) ex = 1'b0;
  endfunction

  task automatic chk(input string tag, input int d, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut=%0d observed=%b expected=%b", tag, d, obs, exp);
    end
  endtask

  task automatic build(input int n, input int last_pos);
    bq_data.delete();
    bq_last.delete();
    for (int i = 0; i < n; i++) begin
      bq_data.push_back(8'($urandom_range(0, 255)));
      bq_last.push_back(i == last_pos);
    end
  endtask

  task automatic run_instance(input int lane, input int d0, input int d1, input bit bp);
    logic ex, ee;
    int   term, budget;
    model(d0, ex, ee, term);
    lane_ordy[lane] = !bp;
    for (int i = 0; i <= term; i++) begin
      lane_valid[lane] = 1'b1;
      lane_data[lane]  = bq_data[i];
      lane_last[lane]  = bq_last[i];
      budget = 50;
      while (!in_ready_w[d0] && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      if (budget == 0) begin
        chk("in_ready_timeout", d0, 1'b0, 1'b1);
        lane_valid[lane] = 1'b0;
        return;
      end
      if (i == term) chk("out_valid_before_terminal", d0, out_valid_w[d0], 1'b0);
      @(posedge clk); #1;
    end
    lane_valid[lane] = 1'b0;
    lane_last[lane]  = 1'b0;
    for (int d = d0; d <= d1; d++) begin
      model(d, ex, ee, term);
      chk("out_valid", d, out_valid_w[d], 1'b1);
      chk("x", d, x_w[d], ex);
      chk("err", d, err_w[d], ee);
      chk("in_ready_in_done", d, in_ready_w[d], 1'b0);
    end
    if (bp) begin
      lane_valid[lane] = 1'b1;
      lane_data[lane]  = 8'($urandom_range(0, 255));
      repeat (5) begin
        @(posedge clk); #1;
        for (int d = d0; d <= d1; d++) begin
          model(d, ex, ee, term);
          chk("bp_out_valid", d, out_valid_w[d], 1'b1);
          chk("bp_x", d, x_w[d], ex);
          chk("bp_err", d, err_w[d], ee);
          chk("bp_in_ready", d, in_ready_w[d], 1'b0);
        end
      end
      lane_valid[lane] = 1'b0;
      lane_ordy[lane]  = 1'b1;
    end
    @(posedge clk); #1;
    for (int d = d0; d <= d1; d++) begin
      chk("out_valid_after_accept", d, out_valid_w[d], 1'b0);
      chk("in_ready_after_accept", d, in_ready_w[d], 1'b1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 5; d++) begin
      chk({tag, "_in_ready"}, d, in_ready_w[d], 1'b0);
      chk({tag, "_out_valid"}, d, out_valid_w[d], 1'b0);
      chk({tag, "_x"}, d, x_w[d], 1'b0);
      chk({tag, "_err"}, d, err_w[d], 1'b0);
    end
  endtask

  initial begin
    for (int l = 0; l < 3; l++) begin
      lane_valid[l] = 1'b0;
      lane_data[l]  = '0;
      lane_last[l]  = 1'b0;
      lane_ordy[l]  = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // MODE 0, clean 40-beat instance with random data.
    build(40, 39);
    run_instance(0, 0, 0, 1'b0);

    // MODE 2 directed: 0xFF x4.
    bq_data = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bq_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_instance(1, 1, 3, 1'b0);

    // MODE 1 directed parity cases.
    bq_data = '{8'h01, 8'h03, 8'h00};
    bq_last = '{1'b0, 1'b0, 1'b1};
    run_instance(2, 4, 4, 1'b0);
    bq_data = '{8'h01, 8'h01, 8'h00};
    run_instance(2, 4, 4, 1'b0);

    // Framing errors: early flag, then missing flag.
    build(4, 1);
    run_instance(1, 1, 3, 1'b0);
    build(4, -1);
    run_instance(1, 1, 3, 1'b0);

    // Backpressure on the verdict, with an extra beat offered while waiting.
    bq_data = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bq_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_instance(1, 1, 3, 1'b1);

    // Reset after two of four beats, then a clean instance.
    for (int i = 0; i < 2; i++) begin
      lane_valid[1] = 1'b1;
      lane_data[1]  = 8'($urandom_range(0, 255));
      lane_last[1]  = 1'b0;
      @(posedge clk); #1;
    end
    lane_valid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("mid_reset");
    rst = 1'b0;
    bq_data = '{8'h7F, 8'h7F, 8'hFF, 8'hFF};
    bq_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_instance(1, 1, 3, 1'b0);

    // Randomized instances on every lane.
    for (int k = 0; k < 2; k++) begin
      build(40, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : 39);
      run_instance(0, 0, 0, ($urandom_range(0, 3) == 0));
    end
    for (int k = 0; k < 20; k++) begin
      build(4, int'($urandom_range(0, 4)));
      run_instance(1, 1, 3, ($urandom_range(0, 4) == 0));
    end
    for (int k = 0; k < 12; k++) begin
      build(3, int'($urandom_range(0, 3)));
      run_instance(2, 4, 4, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/split_stream_eval.md
# split_stream_eval

Parametrised, sequential successor to the fixed-arity split constraint modules. It accepts one problem instance as a serial stream of NUM_VARS variable values over a valid/ready handshake and evaluates a selectable constraint over them. It returns a single verdict bit `x` plus a framing error flag through an output handshake. It sits between the instance loader and the BDD-solver result collector. MODE 0 reproduces the legacy constant-true split behaviour.

## Interface
- NUM_VARS, 40, number of variable beats per instance (≥1)
- MAX_W, 8, width of each variable beat; narrower variables are zero-extended by the sender
- MODE, 0, constraint: 0 = tautology (x=1), 1 = XOR-parity of all bits equals PARITY, 2 = modular sum equals TARGET
- PARITY, 0, required parity for MODE 1
- SUM_W, 12, accumulator width for MODE 2 (sum is mod 2^SUM_W)
- TARGET, 0, required sum for MODE 2 (SUM_W bits)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  block accepts beat
- in_data  in  MAX_W  variable value
- in_last  in  1  sender marks final beat of instance
- out_valid  out  1  verdict valid
- out_ready  in  1  consumer accepts verdict
- x  out  1  constraint verdict
- err  out  1  framing error: in_last position disagrees with NUM_VARS

## Operation
- Reset values: in_ready=0 for the reset cycle, then 1 in IDLE. out_valid=0, x=0, err=0, beat counter=0, parity=0, sum=0.
- FSM states:
  - IDLE: in_ready=1. An accepted beat (in_valid&in_ready) updates the accumulators from zero, sets count=1 and moves to ACCUM. If that beat is already terminal, go straight to DONE (see below).
  - ACCUM: in_ready=1. Each accepted beat XORs the reduction-XOR of in_data into parity, adds zero-extended in_data into sum (truncating to SUM_W), and increments count.
  - Terminal beat: an accepted beat with in_last=1, or an accepted beat with count+1 == NUM_VARS. On the terminal beat, go to DONE.
  - DONE: in_ready=0, out_valid=1. x and err stay stable until out_valid&out_ready, then return to IDLE with the accumulators cleared.
- err=1 when in_last=1 on beat index ≠ NUM_VARS-1, or when in_last=0 on beat NUM_VARS-1. Termination happens at whichever comes first.
- When err=1, x is forced to 0 in every mode.
- x when err=0:
  - MODE 0: x=1
  - MODE 1: x=(final parity == PARITY)
  - MODE 2: x=(final sum == TARGET)
- Count register width is $clog2(NUM_VARS+1). When NUM_VARS=1, every beat is terminal.

## Timing
- Throughput: one beat per cycle in IDLE/ACCUM. No bubbles between beats.
- Latency: out_valid asserts the cycle after the terminal beat is accepted. x and err are registered and valid in that same cycle.
- Back-to-back instances: at least one idle cycle while in DONE. If out_ready is already high when out_valid asserts, DONE lasts 1 cycle and in_ready returns 1 on the next cycle.
- in_ready and out_valid are never both 1.
- The sender must not depend on in_ready combinationally. in_ready depends only on state.
- rst asserted mid-instance or in DONE: next cycle is IDLE, a pending verdict is discarded, and all outputs take their reset values.
- An in_valid beat arriving while in DONE is not accepted and is held by the sender.

## Structure
- Shared package `split_pkg`:
  - enum `split_mode_e` {MODE_TAUT, MODE_PARITY, MODE_SUM}
  - enum `split_state_e` {S_IDLE, S_ACCUM, S_DONE}
  - function for the terminal-beat test
- One sub-module, `split_accum`, holds the parity and sum registers with clear/enable. The FSM, counter and handshakes stay in `split_stream_eval`.

## Test plan
- MODE 0, NUM_VARS=40, 40 beats of arbitrary data, in_last on beat 39 → x=1, err=0, out_valid on the cycle after beat 39.
- MODE 2, NUM_VARS=4, SUM_W=12, TARGET=0x3FC, data 0xFF×4 → x=1. Repeat with TARGET=0x3FB → x=0. Repeat with SUM_W=8, TARGET=0xFC → x=1 (wrap-around).
- MODE 1, NUM_VARS=3, PARITY=1, data 0x01,0x03,0x00 → x=1. Then data 0x01,0x01,0x00 → x=0.
- Framing errors with NUM_VARS=4:
  - in_last on beat 1 → DONE after 2 beats, err=1, x=0.
  - No in_last on beat 3 → DONE after 4 beats, err=1, x=0.
- Backpressure: out_ready held 0 for 5 cycles → out_valid, x and err stay stable and in_ready=0 throughout. Extra in_valid beats offered during this time are not consumed.
- Reset mid-instance after 2 of 4 beats, then a clean 4-beat instance → the verdict reflects only the second instance.
